// File: rtl/datapath_pkg.sv
// Shared datapath types and helpers for the 28-bit register stage and its drain FIFO.
package datapath_pkg;

    localparam int WORD_W = 28;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } fifo_status_t;

    // Occupancy needs one bit more than the pointer so DEPTH itself is representable.
    function automatic int occ_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic fifo_status_t status_of(input int unsigned lvl, input int unsigned depth);
        if (lvl == 0)
            return ST_EMPTY;
        else if (lvl >= depth)
            return ST_FULL;
        else
            return ST_PARTIAL;
    endfunction

endpackage

// File: rtl/flopenr_reader_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + W'(1);
    end

endmodule

// File: rtl/flopenr_reader.sv
// Drain FIFO behind the enabled register stage: enable-strobed writes, valid/ready reads.
// Optional sticky overflow flag (ovf / ovf_clr) when FLOPENR_READER_STICKY_OVF_EN is defined.
module flopenr_reader
    import datapath_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = 4,
    parameter int DROPW = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en,
    input  logic [WIDTH-1:0]          D_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          Q_out,
    output logic [occ_w(DEPTH)-1:0]   level,
    output logic                      full,
    output logic [DROPW-1:0]          drops
`ifdef FLOPENR_READER_STICKY_OVF_EN
    ,
    input  logic                      ovf_clr,
    output logic                      ovf
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = occ_w(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("flopenr_reader: DEPTH must be a power of two >= 2");
    end

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [LW-1:0]               level_q;
    logic [LW-1:0]               level_nxt;
    logic                        full_q;
    fifo_status_t                status;
    logic                        push;
    logic                        pop;
    logic                        drop;

    assign status = status_of(32'(level_q), DEPTH);
    assign pop    = (status != ST_EMPTY) && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push   = en && (!full_q || pop);
    assign drop   = en && full_q && !pop;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop)
            level_nxt = level_q + LW'(1);
        else if (pop && !push)
            level_nxt = level_q - LW'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= D_in;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level_q <= level_nxt;
            full_q  <= (level_nxt == LW'(DEPTH));
        end
    end

    assign out_valid = (status != ST_EMPTY);
    assign Q_out     = mem[rd_ptr];
    assign level     = level_q;
    assign full      = full_q;

    sat_counter #(
        .W (DROPW)
    ) u_drops (
        .clock (clock),
        .reset (reset),
        .inc   (drop),
        .count (drops)
    );

`ifdef FLOPENR_READER_STICKY_OVF_EN
    // A drop wins over a clear in the same cycle so no overflow goes unreported.
    always_ff @(posedge clock) begin
        if (!reset)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (ovf_clr)
            ovf <= 1'b0;
    end
`endif

endmodule
